// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
// Contents:
//   hz_cause_e  - which priority row currently drives the pipeline controls
//   REG_ZERO    - architectural x0 index; a source or destination of x0 never hazards
//   src_match   - true when a producer rd feeds a live, non-x0 consumer source
package hazard_pkg;

   typedef enum logic [2:0] {
      HZ_NONE,
      HZ_MEM,
      HZ_MD,
      HZ_DATA,
      HZ_FLUSH
   } hz_cause_e;

   localparam logic [31:0] REG_ZERO = 32'd0;

   // Register addresses are passed zero-extended to 32 bits so the helper
   // works for any REG_AW.
   function automatic logic src_match(input logic [31:0] rd,
                                      input logic [31:0] rs,
                                      input logic        use_src);
      return use_src && (rs != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle.
// master : pipeline side, drives the stage status (*_i), receives controls (*_o)
// slave  : hazard unit side
// Signals:
//   stage status : memread/regwrite/rd of ID/EX, memread/rd of EX/MEM,
//                  ID sources and use flags, branch info, md_start, dc_req/ack
//   controls     : pc_write, IF/ID stall/flush, ID/EX stall/bubble,
//                  EX/MEM stall, MEM/WB bubble
//   mem_wait     : registered copy of the previous cycle's D-cache freeze
//   perf_*       : only when HAZARD_PERF_EN is defined
interface hazard_ctrl_if #(parameter int REG_AW = 5);

   logic              memread_idex_i;
   logic              regwrite_idex_i;
   logic [REG_AW-1:0] rd_idex_i;
   logic              memread_exmem_i;
   logic [REG_AW-1:0] rd_exmem_i;
   logic [REG_AW-1:0] rs1_ifid_i;
   logic [REG_AW-1:0] rs2_ifid_i;
   logic              use_rs1_i;
   logic              use_rs2_i;
   logic              is_branch_i;
   logic              br_taken_i;
   logic              md_start_i;
   logic              dc_req_i;
   logic              dc_ack_i;

   logic              pc_write_o;
   logic              ifid_stall_o;
   logic              ifid_flush_o;
   logic              idex_stall_o;
   logic              idex_bubble_o;
   logic              exmem_stall_o;
   logic              memwb_bubble_o;
   logic              mem_wait;
`ifdef HAZARD_PERF_EN
   logic [31:0]       perf_stall_cyc_o;
   logic [31:0]       perf_flush_cnt_o;
`endif

   modport master (
      output memread_idex_i, regwrite_idex_i, rd_idex_i, memread_exmem_i,
             rd_exmem_i, rs1_ifid_i, rs2_ifid_i, use_rs1_i, use_rs2_i,
             is_branch_i, br_taken_i, md_start_i, dc_req_i, dc_ack_i,
      input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
             idex_bubble_o, exmem_stall_o, memwb_bubble_o, mem_wait
`ifdef HAZARD_PERF_EN
      , input perf_stall_cyc_o, perf_flush_cnt_o
`endif
   );

   modport slave (
      input  memread_idex_i, regwrite_idex_i, rd_idex_i, memread_exmem_i,
             rd_exmem_i, rs1_ifid_i, rs2_ifid_i, use_rs1_i, use_rs2_i,
             is_branch_i, br_taken_i, md_start_i, dc_req_i, dc_ack_i,
      output pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
             idex_bubble_o, exmem_stall_o, memwb_bubble_o, mem_wait
`ifdef HAZARD_PERF_EN
      , output perf_stall_cyc_o, perf_flush_cnt_o
`endif
   );

endinterface

// File: rtl/hazard_md_timer.sv
// Multi-cycle EX (mul/div) freeze timer.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   md_start_i     : 1-cycle pulse, mul/div entered EX this cycle
//   busy_o         : front end must freeze this cycle
// A mul/div occupies EX for MD_LAT cycles, so the front end is frozen for
// MD_LAT-1 cycles starting with the start cycle. Starts arriving while the
// counter is running are ignored.
module hazard_md_timer #(
   parameter int MD_LAT = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic md_start_i,
   output logic busy_o
);

   localparam int CNT_W = $clog2(MD_LAT + 1);

   // The start cycle is frozen combinationally, so the counter only has to
   // cover the MD_LAT-2 cycles that follow it.
   localparam logic [CNT_W-1:0] LOAD_VAL = (MD_LAT > 1) ? CNT_W'(MD_LAT - 2) : '0;
   localparam logic             HAS_FREEZE = (MD_LAT > 1);

   logic [CNT_W-1:0] md_cnt;
   logic             take;

   assign take   = md_start_i && (md_cnt == '0) && HAS_FREEZE;
   assign busy_o = (md_cnt != '0) || take;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         md_cnt <= '0;
      else if (take)
         md_cnt <= LOAD_VAL;
      else if (md_cnt != '0)
         md_cnt <= md_cnt - 1'b1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RISC-V pipeline.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   bus            : hazard_ctrl_if.slave (stage status in, stall/flush controls out)
// Priority (highest first): D-cache miss freeze, mul/div freeze, load-use /
// branch operand hazard, taken-branch flush, normal flow. All controls are
// combinational from the inputs and the registered state; during reset every
// control is 0, including pc_write (PC held).
// Optional: define HAZARD_PERF_EN to add the 32-bit saturating counters
// perf_stall_cyc_o (cycles with pc_write=0) and perf_flush_cnt_o (IF/ID flushes).
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   hazard_ctrl_if.slave   bus
);

   logic      memf;
   logic      md_busy;
   logic      lu, br1, br2, data_hz;
   logic      mem_wait;
   hz_cause_e cause;

   hazard_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .md_start_i (bus.md_start_i),
      .busy_o     (md_busy)
   );

   // An ack in the same cycle as the request completes the access: no freeze.
   assign memf = bus.dc_req_i && !bus.dc_ack_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         mem_wait <= 1'b0;
      else
         mem_wait <= memf;
   end

   assign bus.mem_wait = mem_wait;

   // Branches resolve in ID, so an ALU result still in EX or a load result
   // still in MEM is not yet forwardable to the comparator.
   assign lu  = bus.memread_idex_i &&
                (src_match(32'(bus.rd_idex_i), 32'(bus.rs1_ifid_i), bus.use_rs1_i) ||
                 src_match(32'(bus.rd_idex_i), 32'(bus.rs2_ifid_i), bus.use_rs2_i));
   assign br1 = bus.is_branch_i && bus.regwrite_idex_i &&
                (src_match(32'(bus.rd_idex_i), 32'(bus.rs1_ifid_i), bus.use_rs1_i) ||
                 src_match(32'(bus.rd_idex_i), 32'(bus.rs2_ifid_i), bus.use_rs2_i));
   assign br2 = bus.is_branch_i && bus.memread_exmem_i &&
                (src_match(32'(bus.rd_exmem_i), 32'(bus.rs1_ifid_i), bus.use_rs1_i) ||
                 src_match(32'(bus.rd_exmem_i), 32'(bus.rs2_ifid_i), bus.use_rs2_i));
   assign data_hz = lu || br1 || br2;

   // A stalled branch is never flushed: br_taken_i is only meaningful once
   // the operands are clean, and the branch is re-evaluated every cycle.
   always_comb begin
      cause = HZ_NONE;
      if (memf)
         cause = HZ_MEM;
      else if (md_busy)
         cause = HZ_MD;
      else if (data_hz)
         cause = HZ_DATA;
      else if (bus.is_branch_i && bus.br_taken_i)
         cause = HZ_FLUSH;
   end

   always_comb begin
      bus.pc_write_o     = 1'b0;
      bus.ifid_stall_o   = 1'b0;
      bus.ifid_flush_o   = 1'b0;
      bus.idex_stall_o   = 1'b0;
      bus.idex_bubble_o  = 1'b0;
      bus.exmem_stall_o  = 1'b0;
      bus.memwb_bubble_o = 1'b0;
      if (rst_n_i) begin
         case (cause)
            HZ_MEM: begin
               bus.ifid_stall_o   = 1'b1;
               bus.idex_stall_o   = 1'b1;
               bus.exmem_stall_o  = 1'b1;
               bus.memwb_bubble_o = 1'b1;
            end
            // EX/MEM is left running so it takes a NOP while the mul/div
            // sits in EX behind the held ID/EX register.
            HZ_MD: begin
               bus.ifid_stall_o = 1'b1;
               bus.idex_stall_o = 1'b1;
            end
            HZ_DATA: begin
               bus.ifid_stall_o  = 1'b1;
               bus.idex_bubble_o = 1'b1;
            end
            HZ_FLUSH: begin
               bus.pc_write_o   = 1'b1;
               bus.ifid_flush_o = 1'b1;
            end
            default: bus.pc_write_o = 1'b1;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cyc;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cyc <= '0;
         flush_cnt <= '0;
      end else begin
         if (!bus.pc_write_o && (stall_cyc != '1))
            stall_cyc <= stall_cyc + 32'd1;
         if (bus.ifid_flush_o && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign bus.perf_stall_cyc_o = stall_cyc;
   assign bus.perf_flush_cnt_o = flush_cnt;
`endif

endmodule
